majority_bist: RTL and testbench

- Built-in self-test engine for the 3-input majority circuit `majority_c`; the hardware counterpart of the bench stimulus.
- Drives all 8 input combinations onto A/B/C in sequence, waits a settle interval, samples F and compares it with a golden majority function.
- Reports pass/fail, the failure count and the first failing vector.
- Sits beside `majority_c` on the lab board. Outputs are registered; F is sampled in the same clock domain, so no synchronizer is needed.

---
 rtl/majority_bist_pkg.sv | 18 +
 rtl/majority_bist_if.sv | 26 ++
 rtl/majority_golden.sv | 13 +
 rtl/majority_bist.sv | 127 ++++++++++++
 tb/tb_majority_bist.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/majority_bist_pkg.sv
// Shared types and helpers for the majority-circuit self-test engine.
package majority_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  localparam int unsigned NUM_VECTORS = 8;
  localparam logic [2:0]  LAST_VEC    = 3'b111;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/majority_bist_if.sv
// Stimulus/response and result signals between the BIST engine and the lab board.
interface majority_bist_if;
  logic       start;
  logic       abort;
  logic       A;
  logic       B;
  logic       C;
  logic       F;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_count;
  logic [2:0] first_fail_vec;
  logic       first_fail_valid;

  // master: the board/controller side that drives start/abort and returns F
  modport master (
    output start, abort, F,
    input  A, B, C, busy, done, pass, fail_count, first_fail_vec, first_fail_valid
  );

  modport slave (
    input  start, abort, F,
    output A, B, C, busy, done, pass, fail_count, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/majority_golden.sv
// Combinational golden reference for the circuit under test.
module majority_golden
  import majority_bist_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic f_exp
);

  assign f_exp = maj3(a, b, c);

endmodule

// File: rtl/majority_bist.sv
// BIST engine: walks {A,B,C} through 000..111, samples F after a settle interval
// and compares it with the golden majority function.
module majority_bist
  import majority_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  majority_bist_if.slave bus
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("majority_bist: SETTLE_CYCLES must be in 1..15");
  end
  if (LAST_VEC != 3'(NUM_VECTORS - 1)) begin : g_bad_vec
    $error("majority_bist: LAST_VEC inconsistent with NUM_VECTORS");
  end

  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_q;
  state_t     state_d;
  logic [2:0] vec_q;
  logic [3:0] cnt_q;
  logic [3:0] fail_count_q;
  logic [3:0] fail_count_nx;
  logic [2:0] first_fail_vec_q;
  logic       first_fail_valid_q;
  logic       pass_q;
  logic       f_exp;
  logic       mismatch;

  majority_golden u_golden (
    .a     (vec_q[2]),
    .b     (vec_q[1]),
    .c     (vec_q[0]),
    .f_exp (f_exp)
  );

  assign mismatch      = (state_q == CHECK) && (bus.F != f_exp);
  assign fail_count_nx = fail_count_q + 4'(mismatch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (bus.start) state_d = SETTLE;
        SETTLE:     if (cnt_q == '0) state_d = CHECK;
        CHECK:      state_d = (vec_q == LAST_VEC) ? DONE : SETTLE;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q              <= '0;
      cnt_q              <= '0;
      fail_count_q       <= '0;
      first_fail_vec_q   <= '0;
      first_fail_valid_q <= 1'b0;
      pass_q             <= 1'b0;
    end else if (bus.abort) begin
      vec_q              <= '0;
      cnt_q              <= '0;
      fail_count_q       <= '0;
      first_fail_vec_q   <= '0;
      first_fail_valid_q <= 1'b0;
      pass_q             <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            vec_q              <= '0;
            cnt_q              <= RELOAD;
            fail_count_q       <= '0;
            first_fail_vec_q   <= '0;
            first_fail_valid_q <= 1'b0;
            pass_q             <= 1'b0;
          end
        end
        SETTLE: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 4'd1;
        end
        CHECK: begin
          fail_count_q <= fail_count_nx;
          if (mismatch && !first_fail_valid_q) begin
            first_fail_vec_q   <= vec_q;
            first_fail_valid_q <= 1'b1;
          end
          // pass uses the post-check count so the last vector is included
          if (vec_q == LAST_VEC) begin
            pass_q <= (fail_count_nx == '0);
          end else begin
            vec_q <= vec_q + 3'd1;
            cnt_q <= RELOAD;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy             = (state_q == SETTLE) || (state_q == CHECK);
    bus.done             = (state_q == DONE);
    bus.pass             = pass_q;
    bus.A                = vec_q[2];
    bus.B                = vec_q[1];
    bus.C                = vec_q[0];
    bus.fail_count       = fail_count_q;
    bus.first_fail_vec   = first_fail_vec_q;
    bus.first_fail_valid = first_fail_valid_q;
  end

endmodule

// File: tb/tb_majority_bist.sv
// Self-checking bench for majority_bist with three models of the circuit under test.
module tb_majority_bist;
  localparam int S = 2;
  localparam int P = S + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   mode = 0;  // 0 = correct majority, 1 = stuck-at-0, 2 = inverted
  int   n_cmp = 0;
  int   n_bad = 0;

  majority_bist_if bus ();

  majority_bist #(.SETTLE_CYCLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int ref_maj(input int v);
    return ($countones(3'(v)) >= 2) ? 1 : 0;
  endfunction

  function automatic int resp(input int md, input int v);
    if (md == 1) return 0;
    if (md == 2) return 1 - ref_maj(v);
    return ref_maj(v);
  endfunction

  function automatic int fails_upto(input int md, input int n);
    int cnt = 0;
    for (int v = 0; v < n; v++) if (resp(md, v) != ref_maj(v)) cnt++;
    return cnt;
  endfunction

  function automatic int first_fail(input int md, input int n);
    for (int v = 0; v < n; v++) if (resp(md, v) != ref_maj(v)) return v;
    return 0;
  endfunction

  always_comb bus.F = (resp(mode, {29'd0, bus.A, bus.B, bus.C}) != 0);

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: cycle k of a pass (1-based) shows vector (k-1)/P and has
  // that many vectors already judged.
  int m_busy = 0;
  int m_done = 0;
  int m_k    = 0;
  int m_mode = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_k <= 0;
    end else if (bus.abort) begin
      m_busy <= 0; m_done <= 0; m_k <= 0;
    end else if (bus.start && m_busy == 0) begin
      m_busy <= 1; m_done <= 0; m_k <= 1; m_mode <= mode;
    end else if (m_busy != 0) begin
      if (m_k == 8 * P) begin
        m_busy <= 0; m_done <= 1;
      end
      m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    int n_chk, e_abc, e_fc;
    n_chk = (m_busy != 0) ? (m_k - 1) / P : ((m_done != 0) ? 8 : 0);
    e_abc = (m_busy != 0) ? (m_k - 1) / P : ((m_done != 0) ? 7 : 0);
    e_fc  = fails_upto(m_mode, n_chk);
    chk("busy", int'(bus.busy), m_busy);
    chk("done", int'(bus.done), m_done);
    chk("abc", int'({bus.A, bus.B, bus.C}), e_abc);
    chk("fail_count", int'(bus.fail_count), e_fc);
    chk("first_fail_valid", int'(bus.first_fail_valid), (e_fc != 0) ? 1 : 0);
    chk("first_fail_vec", int'(bus.first_fail_vec), first_fail(m_mode, n_chk));
    chk("pass", int'(bus.pass), (m_done != 0 && e_fc == 0) ? 1 : 0);
  end

  task automatic do_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cyc);
    int t = 0;
    busy_cyc = 0;
    while (!bus.done && t < 200) begin
      if (bus.busy) busy_cyc++;
      @(negedge clk);
      t++;
    end
    chk("done_timeout", int'(bus.done), 1);
  endtask

  task automatic chk_results(input string tag, input int fc, input int ffv,
                             input int ffvalid, input int ps);
    chk({tag, "_done"}, int'(bus.done), 1);
    chk({tag, "_fc"}, int'(bus.fail_count), fc);
    chk({tag, "_ffv"}, int'(bus.first_fail_vec), ffv);
    chk({tag, "_ffvalid"}, int'(bus.first_fail_valid), ffvalid);
    chk({tag, "_pass"}, int'(bus.pass), ps);
    chk({tag, "_abc"}, int'({bus.A, bus.B, bus.C}), 7);
  endtask

  initial begin
    int bc;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_fc", int'(bus.fail_count), 0);
    rst_n = 1'b1;

    // correct circuit
    mode = 0;
    do_start();
    wait_done(bc);
    chk("t1_busy_cycles", bc, 24);
    chk_results("t1", 0, 0, 0, 1);

    // stuck-at-0, rerun from DONE
    mode = 1;
    do_start();
    wait_done(bc);
    chk("t2_busy_cycles", bc, 24);
    chk_results("t2", 4, 3, 1, 0);

    // inverted majority
    mode = 2;
    do_start();
    wait_done(bc);
    chk_results("t3", 8, 0, 1, 0);

    // reset during vector 101 (cycles 16..18 of the pass)
    mode = 0;
    do_start();
    repeat (16) @(negedge clk);
    chk("t4_vec_before_rst", int'({bus.A, bus.B, bus.C}), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_abc", int'({bus.A, bus.B, bus.C}), 0);
    chk("t4_busy", int'(bus.busy), 0);
    chk("t4_done", int'(bus.done), 0);
    chk("t4_pass", int'(bus.pass), 0);
    chk("t4_fc", int'(bus.fail_count), 0);
    chk("t4_ffvalid", int'(bus.first_fail_valid), 0);
    @(negedge clk) rst_n = 1'b1;

    // abort during vector 010 with two failures already counted
    mode = 2;
    do_start();
    repeat (7) @(negedge clk);
    chk("t5_vec", int'({bus.A, bus.B, bus.C}), 2);
    chk("t5_fc_before", int'(bus.fail_count), 2);
    bus.abort = 1'b1;
    @(negedge clk) bus.abort = 1'b0;
    chk("t5_busy", int'(bus.busy), 0);
    chk("t5_done", int'(bus.done), 0);
    chk("t5_fc", int'(bus.fail_count), 0);
    chk("t5_ffvalid", int'(bus.first_fail_valid), 0);

    // start re-asserted at cycles 5 and 10 is ignored
    mode = 0;
    do_start();
    repeat (4) @(negedge clk) ;
    bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    wait_done(bc);
    chk("t6_busy_rest", bc, 14);
    chk_results("t6", 0, 0, 0, 1);
    do_start();
    wait_done(bc);
    chk("t6b_busy_cycles", bc, 24);
    chk_results("t6b", 0, 0, 0, 1);

    // start and abort together in DONE: abort wins
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("t7_busy", int'(bus.busy), 0);
    chk("t7_done", int'(bus.done), 0);
    chk("t7_abc", int'({bus.A, bus.B, bus.C}), 0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
